// File: rtl/mii_arb_pkg.sv
// Shared types and helpers for the MII egress arbiter and its round-robin picker.
package mii_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_CNT_WIDTH = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at index >= ptr, wrapping around.
module rr_pick
    import mii_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 3,
    localparam int unsigned IDX_W  = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] pick,
    output logic               valid
);

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        // Upper segment [ptr, N_PORTS-1] outranks the wrapped segment [0, ptr-1].
        for (int i = 0; i < N_PORTS; i++) begin
            if (!valid && req[i] && (IDX_W'(i) >= ptr)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (!valid && req[i] && (IDX_W'(i) < ptr)) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mii_egress_arbiter.sv
// Packet-granular round-robin arbiter sharing one MAC TX AXI-stream among N_PORTS sources.
// Optional per-source packet counters are built when MII_EGRESS_ARB_STATS_EN is defined.
module mii_egress_arbiter
    import mii_arb_pkg::*;
#(
    parameter int unsigned N_PORTS    = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_PORTS*DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [N_PORTS-1:0]                  s_axis_tvalid,
    output logic [N_PORTS-1:0]                  s_axis_tready,
    input  logic [N_PORTS-1:0]                  s_axis_tlast,
    input  logic [N_PORTS*USER_WIDTH-1:0]       s_axis_tuser,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [USER_WIDTH-1:0]               m_axis_tuser,
    output logic [N_PORTS-1:0]                  grant,
    output logic                                busy,
    output logic [N_PORTS*STAT_CNT_WIDTH-1:0]   stat_pkt_cnt
);

    localparam int unsigned IDX_W = idx_width(N_PORTS);

    arb_state_e         state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_PORTS-1:0] pick;
    logic               pick_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               last_xfer;

    rr_pick #(
        .N_PORTS(N_PORTS)
    ) u_rr_pick (
        .req  (s_axis_tvalid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .valid(pick_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) grant_idx = IDX_W'(i);
        end
    end

    assign last_xfer = (state_q == ARB_ACTIVE) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ARB_ACTIVE;
                end
            end
            ARB_ACTIVE: begin
                // The finishing source drops to lowest priority for the next round.
                if (last_xfer) begin
                    grant_d  = '0;
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == ARB_ACTIVE) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (grant_q[i]) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_ACTIVE);

`ifdef MII_EGRESS_ARB_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] cnt_q [N_PORTS];
    logic [STAT_CNT_WIDTH-1:0] cnt_d [N_PORTS];

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_axis_tready[i] && s_axis_tvalid[i] && s_axis_tlast[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        stat_pkt_cnt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            stat_pkt_cnt[i*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = cnt_q[i];
        end
    end
`else
    assign stat_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_mii_egress_arbiter.sv
// Self-checking bench for mii_egress_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mii_egress_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_axis_tdata;
    logic [2:0]  s_axis_tvalid;
    logic [2:0]  s_axis_tready;
    logic [2:0]  s_axis_tlast;
    logic [2:0]  s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic [2:0]  grant;
    logic        busy;
    logic [47:0] stat_pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mii_egress_arbiter #(
        .N_PORTS   (3),
        .DATA_WIDTH(8),
        .USER_WIDTH(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .grant        (grant),
        .busy         (busy),
        .stat_pkt_cnt (stat_pkt_cnt)
    );

    typedef struct {
        logic [2:0]  vld;
        logic [2:0]  lst;
        logic [2:0]  usr;
        logic [23:0] data;
        logic        mrdy;
        logic [2:0]  e_grant;
        logic        e_mvld;
        logic [7:0]  e_mdata;
        logic        e_mlast;
        logic        e_muser;
        logic [2:0]  e_srdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beat;
        int first_cyc;
        int last_cyc;
        int idle_cyc;
        logic [47:0] exp_stat;

        // Round-robin walk, backpressure, mid-packet stall and a stall-free idle tail.
        vecs[0]  = '{3'b111, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{3'b111, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b001, 1'b1, 8'hA0, 1'b0, 1'b0, 3'b001, 1'b1};
        vecs[2]  = '{3'b111, 3'b001, 3'b000, 24'hC2B1A1, 1'b1, 3'b001, 1'b1, 8'hA1, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[4]  = '{3'b111, 3'b010, 3'b010, 24'hC2B1A0, 1'b1, 3'b010, 1'b1, 8'hB1, 1'b1, 1'b1, 3'b010, 1'b1};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[6]  = '{3'b111, 3'b100, 3'b000, 24'hC2B1A0, 1'b0, 3'b100, 1'b1, 8'hC2, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[7]  = '{3'b111, 3'b100, 3'b000, 24'hC2B1A0, 1'b1, 3'b100, 1'b1, 8'hC2, 1'b1, 1'b0, 3'b100, 1'b1};
        vecs[8]  = '{3'b010, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[9]  = '{3'b000, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b010, 1'b0, 8'hB1, 1'b0, 1'b0, 3'b010, 1'b1};
        vecs[10] = '{3'b011, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b010, 1'b1, 8'hB1, 1'b0, 1'b0, 3'b010, 1'b1};
        vecs[11] = '{3'b011, 3'b010, 3'b000, 24'hC2B1A0, 1'b1, 3'b010, 1'b1, 8'hB1, 1'b1, 1'b0, 3'b010, 1'b1};
        vecs[12] = '{3'b001, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[13] = '{3'b001, 3'b001, 3'b000, 24'hC2B1A0, 1'b1, 3'b001, 1'b1, 8'hA0, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[14] = '{3'b000, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[15] = '{3'b000, 3'b000, 3'b000, 24'hC2B1A0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0};

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        #3;
        chk("reset grant", 64'(grant), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset m_tvalid", 64'(m_axis_tvalid), 64'h0);
        chk("reset s_tready", 64'(s_axis_tready), 64'h0);
        chk("reset stat", 64'(stat_pkt_cnt), 64'h0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            s_axis_tvalid = vecs[i].vld;
            s_axis_tlast  = vecs[i].lst;
            s_axis_tuser  = vecs[i].usr;
            s_axis_tdata  = vecs[i].data;
            m_axis_tready = vecs[i].mrdy;
            @(negedge clk);
            chk($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
            chk($sformatf("vec%0d m_tvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].e_mvld));
            chk($sformatf("vec%0d m_tdata", i), 64'(m_axis_tdata), 64'(vecs[i].e_mdata));
            chk($sformatf("vec%0d m_tlast", i), 64'(m_axis_tlast), 64'(vecs[i].e_mlast));
            chk($sformatf("vec%0d m_tuser", i), 64'(m_axis_tuser), 64'(vecs[i].e_muser));
            chk($sformatf("vec%0d s_tready", i), 64'(s_axis_tready), 64'(vecs[i].e_srdy));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            step();
        end

        // Reset mid-packet: rr_ptr is 1 here, so only a real reset lets src0 win afterwards.
        s_axis_tvalid = 3'b010;
        s_axis_tlast  = 3'b000;
        s_axis_tuser  = 3'b000;
        m_axis_tready = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            s_axis_tdata = {8'hCC, 8'(k), 8'hAA};
            @(negedge clk);
            chk($sformatf("rstseq beat%0d data", k), 64'(m_axis_tdata), 64'(k));
            step();
        end
        s_axis_tdata = {8'hCC, 8'd9, 8'hAA};
        rst = 1'b1;
        #1;
        chk("rstseq grant", 64'(grant), 64'h0);
        chk("rstseq m_tvalid", 64'(m_axis_tvalid), 64'h0);
        chk("rstseq s_tready", 64'(s_axis_tready), 64'h0);
        chk("rstseq busy", 64'(busy), 64'h0);
        step();
        rst           = 1'b0;
        s_axis_tvalid = 3'b111;
        step();
        @(negedge clk);
        chk("rstseq post grant", 64'(grant), 64'h1);
        step();
        s_axis_tlast = 3'b001;
        @(negedge clk);
        chk("rstseq post tlast", 64'(m_axis_tlast), 64'h1);
        step();
        s_axis_tvalid = 3'b000;
        s_axis_tlast  = 3'b000;
        step();

        // Three back-to-back 64-beat packets from src1.
        beat      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        idle_cyc  = 0;
        for (int cyc = 0; cyc < 400 && beat < 192; cyc++) begin
            s_axis_tvalid = 3'b010;
            s_axis_tdata  = {8'h00, 8'(beat), 8'h00};
            s_axis_tlast  = {1'b0, (beat % 64) == 63, 1'b0};
            @(negedge clk);
            if (s_axis_tready[1]) begin
                chk($sformatf("b2b beat%0d data", beat), 64'(m_axis_tdata), 64'(beat[7:0]));
                chk($sformatf("b2b beat%0d grant", beat), 64'(grant), 64'h2);
                if (first_cyc < 0) first_cyc = cyc;
                if (beat == 191) last_cyc = cyc;
                beat++;
            end else if (beat > 0) begin
                idle_cyc++;
            end
            step();
        end
        chk("b2b beats", 64'(beat), 64'd192);
        chk("b2b idle cycles", 64'(idle_cyc), 64'd2);
        chk("b2b span", 64'(last_cyc - first_cyc + 1), 64'd194);
        s_axis_tvalid = 3'b000;
        s_axis_tlast  = 3'b000;
        step();

        // Backpressure on a src2 packet while src0/src1 also request (rr_ptr is 2).
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            s_axis_tvalid = 3'b111;
            s_axis_tdata  = {8'(beat), 8'hBB, 8'hAA};
            s_axis_tlast  = {beat == 3, 1'b0, 1'b0};
            m_axis_tready = cyc[0];
            @(negedge clk);
            if (busy) begin
                chk($sformatf("bp cyc%0d s_tready", cyc), 64'(s_axis_tready),
                    64'({m_axis_tready, 2'b00}));
                chk($sformatf("bp cyc%0d grant", cyc), 64'(grant), 64'h4);
                chk($sformatf("bp cyc%0d data", cyc), 64'(m_axis_tdata), 64'(beat));
                if (m_axis_tready) beat++;
            end
            step();
        end
        chk("bp beats", 64'(beat), 64'd4);
        s_axis_tvalid = 3'b000;
        s_axis_tlast  = 3'b000;
        m_axis_tready = 1'b1;
        step();
        step();

`ifdef MII_EGRESS_ARB_STATS_EN
        exp_stat = {16'd1, 16'd3, 16'd1};
`else
        exp_stat = 48'h0;
`endif
        @(negedge clk);
        chk("stat_pkt_cnt", 64'(stat_pkt_cnt), 64'(exp_stat));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
